d2d_link_arbiter: RTL and testbench

Parametrised die-to-die request arbiter for the bottom die. It merges NCH blocking L1 request channels (e.g. L1I, L1D, future ports) onto one tagged cross-die link to the L2 on the top die. Each channel gets a one-entry request buffer, round-robin arbitration, link backpressure, ID-tagged response routing and a per-channel response timeout with error reporting. This generalises the fixed two-channel, untagged icache/dcache wiring.

---
 rtl/d2d_link_arbiter.sv | 142 ++++++++++++++
 tb/tb_d2d_link_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d2d_link_arbiter.sv
// rtl/d2d_link_arbiter.sv - round-robin merge of NCH blocking L1 request channels onto one tagged die-to-die link
// Each channel owns a one-entry buffer; responses route back by link ID, with a per-channel timeout.
module d2d_link_arbiter #(
   parameter int NCH     = 2,
   parameter int IDW     = 1,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH-1:0]    ch_req_valid_i,
   output logic [NCH-1:0]    ch_req_ready_o,
   input  logic [NCH*AW-1:0] ch_req_addr_i,
   input  logic [NCH-1:0]    ch_req_we_i,
   input  logic [NCH*DW-1:0] ch_req_dat_i,
   output logic [NCH-1:0]    ch_rsp_valid_o,
   output logic [NCH*DW-1:0] ch_rsp_dat_o,
   output logic [NCH-1:0]    ch_rsp_err_o,
   output logic              link_valid_o,
   input  logic              link_ready_i,
   output logic [AW-1:0]     link_addr_o,
   output logic              link_we_o,
   output logic [DW-1:0]     link_dat_o,
   output logic [IDW-1:0]    link_id_o,
   input  logic              link_rsp_valid_i,
   input  logic [IDW-1:0]    link_rsp_id_i,
   input  logic [DW-1:0]     link_rsp_dat_i,
   output logic              stray_o
);

   if ((2 ** IDW) < NCH) begin : g_bad_idw
      $error("d2d_link_arbiter: IDW too narrow to tag NCH channels");
   end

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_OUT} ch_state_t;

   ch_state_t      state_q [NCH];
   ch_state_t      state_d [NCH];
   logic [AW-1:0]  buf_addr [NCH];
   logic [DW-1:0]  buf_dat [NCH];
   logic [NCH-1:0] buf_we;
   logic [CW-1:0]  cnt_q [NCH];
   logic [IDW-1:0] rr_ptr;

   logic [NCH-1:0] accept, expire, rsp_hit, gnt_oh;
   logic           load, rsp_stray;
   int             off, best_off;

   always_comb begin
      load     = !link_valid_o || link_ready_i;
      gnt_oh   = '0;
      best_off = NCH;
      off      = 0;
      rsp_hit  = '0;
      for (int k = 0; k < NCH; k++) begin
         ch_req_ready_o[k] = (state_q[k] == ST_IDLE);
         accept[k]         = ch_req_valid_i[k] && ch_req_ready_o[k];
         expire[k]         = (TIMEOUT > 0) && (state_q[k] == ST_OUT) && (cnt_q[k] == TO_LAST);
         rsp_hit[k]        = link_rsp_valid_i && (link_rsp_id_i == IDW'(k)) && (state_q[k] == ST_OUT);
         // distance from the rr pointer, wrapping modulo NCH; smallest distance wins
         off = (k >= int'(rr_ptr)) ? (k - int'(rr_ptr)) : (k + NCH - int'(rr_ptr));
         if ((state_q[k] == ST_PEND) && (off < best_off)) begin
            best_off  = off;
            gnt_oh    = '0;
            gnt_oh[k] = 1'b1;
         end
      end
      rsp_stray = link_rsp_valid_i && !(|rsp_hit);
   end

   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         state_d[k] = state_q[k];
         case (state_q[k])
            ST_IDLE: if (accept[k])             state_d[k] = ST_PEND;
            ST_PEND: if (load && gnt_oh[k])     state_d[k] = ST_OUT;
            ST_OUT:  if (rsp_hit[k] || expire[k]) state_d[k] = ST_IDLE;
            default:                            state_d[k] = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NCH; k++) begin
         if (!rst_n) state_q[k] <= ST_IDLE;
         else        state_q[k] <= state_d[k];
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NCH; k++) begin
         if (accept[k]) begin
            buf_addr[k] <= ch_req_addr_i[k*AW +: AW];
            buf_dat[k]  <= ch_req_dat_i[k*DW +: DW];
            buf_we[k]   <= ch_req_we_i[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr         <= '0;
         link_valid_o   <= 1'b0;
         link_addr_o    <= '0;
         link_we_o      <= 1'b0;
         link_dat_o     <= '0;
         link_id_o      <= '0;
         ch_rsp_valid_o <= '0;
         ch_rsp_err_o   <= '0;
         ch_rsp_dat_o   <= '0;
         stray_o        <= 1'b0;
         for (int k = 0; k < NCH; k++) cnt_q[k] <= '0;
      end else begin
         if (load) begin
            link_valid_o <= |gnt_oh;
            for (int k = 0; k < NCH; k++) begin
               if (gnt_oh[k]) begin
                  link_addr_o <= buf_addr[k];
                  link_we_o   <= buf_we[k];
                  link_dat_o  <= buf_dat[k];
                  link_id_o   <= IDW'(k);
                  rr_ptr      <= IDW'((k + 1) % NCH);
               end
            end
         end
         // a response landing on the expiry cycle beats the timeout
         for (int k = 0; k < NCH; k++) begin
            ch_rsp_valid_o[k]           <= rsp_hit[k] || expire[k];
            ch_rsp_err_o[k]             <= expire[k] && !rsp_hit[k];
            ch_rsp_dat_o[k*DW +: DW]    <= rsp_hit[k] ? link_rsp_dat_i : '0;
            if (state_q[k] == ST_OUT && TIMEOUT > 0) cnt_q[k] <= cnt_q[k] + 1'b1;
            else                                     cnt_q[k] <= '0;
         end
         if (rsp_stray) stray_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_d2d_link_arbiter.sv
// tb/tb_d2d_link_arbiter.sv - directed and randomized bench for d2d_link_arbiter against a transaction-level model
module tb_d2d_link_arbiter;

   localparam int NCH = 3;
   localparam int IDW = 2;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH-1:0]    ch_req_valid_i;
   logic [NCH-1:0]    ch_req_ready_o;
   logic [NCH*AW-1:0] ch_req_addr_i;
   logic [NCH-1:0]    ch_req_we_i;
   logic [NCH*DW-1:0] ch_req_dat_i;
   logic [NCH-1:0]    ch_rsp_valid_o;
   logic [NCH*DW-1:0] ch_rsp_dat_o;
   logic [NCH-1:0]    ch_rsp_err_o;
   logic              link_valid_o;
   logic              link_ready_i;
   logic [AW-1:0]     link_addr_o;
   logic              link_we_o;
   logic [DW-1:0]     link_dat_o;
   logic [IDW-1:0]    link_id_o;
   logic              link_rsp_valid_i;
   logic [IDW-1:0]    link_rsp_id_i;
   logic [DW-1:0]     link_rsp_dat_i;
   logic              stray_o;

   d2d_link_arbiter #(.NCH(NCH), .IDW(IDW), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .ch_req_valid_i(ch_req_valid_i), .ch_req_ready_o(ch_req_ready_o),
      .ch_req_addr_i(ch_req_addr_i), .ch_req_we_i(ch_req_we_i), .ch_req_dat_i(ch_req_dat_i),
      .ch_rsp_valid_o(ch_rsp_valid_o), .ch_rsp_dat_o(ch_rsp_dat_o), .ch_rsp_err_o(ch_rsp_err_o),
      .link_valid_o(link_valid_o), .link_ready_i(link_ready_i), .link_addr_o(link_addr_o),
      .link_we_o(link_we_o), .link_dat_o(link_dat_o), .link_id_o(link_id_o),
      .link_rsp_valid_i(link_rsp_valid_i), .link_rsp_id_i(link_rsp_id_i),
      .link_rsp_dat_i(link_rsp_dat_i), .stray_o(stray_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // transaction model: a channel holds a request from acceptance until its response or timeout
   bit          m_has [NCH];
   bit          m_iss [NCH];
   int          m_iss_edge [NCH];
   logic [31:0] m_addr [NCH];
   logic [31:0] m_dat [NCH];
   bit          m_we [NCH];
   bit          m_lv;
   logic [31:0] m_la, m_ld;
   bit          m_lwe;
   int          m_lid, m_ptr, edge_n;
   bit          m_stray;
   bit          e_rv [NCH];
   bit          e_err [NCH];
   logic [31:0] e_rd [NCH];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int  hit;
      int  g;
      bit  acc [NCH];
      bit  done [NCH];
      edge_n++;
      if (!rst_n) begin
         for (int k = 0; k < NCH; k++) begin
            m_has[k] = 0; m_iss[k] = 0; e_rv[k] = 0; e_err[k] = 0; e_rd[k] = '0;
         end
         m_lv = 0; m_ptr = 0; m_stray = 0;
         return;
      end
      for (int k = 0; k < NCH; k++) begin
         acc[k]  = ch_req_valid_i[k] && !m_has[k];
         done[k] = 0; e_rv[k] = 0; e_err[k] = 0; e_rd[k] = '0;
      end
      hit = -1;
      if (link_rsp_valid_i) begin
         if (int'(link_rsp_id_i) < NCH && m_iss[int'(link_rsp_id_i)]) hit = int'(link_rsp_id_i);
         else m_stray = 1;
      end
      if (hit >= 0) begin
         e_rv[hit] = 1; e_rd[hit] = link_rsp_dat_i; done[hit] = 1;
      end
      for (int k = 0; k < NCH; k++)
         if (k != hit && m_iss[k] && (edge_n - m_iss_edge[k]) == TMO) begin
            e_rv[k] = 1; e_err[k] = 1; done[k] = 1;
         end
      if (!m_lv || link_ready_i) begin
         g = -1;
         for (int i = 0; i < NCH; i++) begin
            int c = (m_ptr + i) % NCH;
            if (g < 0 && m_has[c] && !m_iss[c]) g = c;
         end
         if (g >= 0) begin
            m_lv = 1; m_la = m_addr[g]; m_ld = m_dat[g]; m_lwe = m_we[g]; m_lid = g;
            m_iss[g] = 1; m_iss_edge[g] = edge_n; m_ptr = (g + 1) % NCH;
         end else m_lv = 0;
      end
      for (int k = 0; k < NCH; k++) begin
         if (done[k]) begin m_has[k] = 0; m_iss[k] = 0; end
         if (acc[k]) begin
            m_has[k] = 1; m_iss[k] = 0;
            m_addr[k] = ch_req_addr_i[k*AW +: AW];
            m_dat[k]  = ch_req_dat_i[k*DW +: DW];
            m_we[k]   = ch_req_we_i[k];
         end
      end
   endtask

   task automatic compare_all();
      logic [NCH-1:0] er, ev;
      for (int k = 0; k < NCH; k++) begin
         er[k] = !m_has[k];
         ev[k] = e_rv[k];
      end
      chk("ready", ch_req_ready_o, er);
      chk("link_valid", link_valid_o, m_lv);
      if (m_lv) begin
         chk("link_addr", link_addr_o, m_la);
         chk("link_we", link_we_o, m_lwe);
         chk("link_dat", link_dat_o, m_ld);
         chk("link_id", link_id_o, m_lid);
      end
      chk("rsp_valid", ch_rsp_valid_o, ev);
      for (int k = 0; k < NCH; k++)
         if (e_rv[k]) begin
            chk("rsp_dat", ch_rsp_dat_o[k*DW +: DW], e_rd[k]);
            chk("rsp_err", ch_rsp_err_o[k], e_err[k]);
         end
      chk("stray", stray_o, m_stray);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic set_req(input int k, input logic [31:0] a, input logic we, input logic [31:0] d);
      ch_req_valid_i[k]          = 1'b1;
      ch_req_addr_i[k*AW +: AW]  = a;
      ch_req_we_i[k]             = we;
      ch_req_dat_i[k*DW +: DW]   = d;
   endtask

   task automatic send_rsp(input int id, input logic [31:0] d);
      link_rsp_valid_i = 1'b1;
      link_rsp_id_i    = IDW'(id);
      link_rsp_dat_i   = d;
      step();
      link_rsp_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      int cand[$];
      edge_n = 0;
      ch_req_valid_i = '0; ch_req_addr_i = '0; ch_req_we_i = '0; ch_req_dat_i = '0;
      link_ready_i = 1'b1; link_rsp_valid_i = 1'b0; link_rsp_id_i = '0; link_rsp_dat_i = '0;
      do_reset();
      chk("reset_ready", ch_req_ready_o, 3'b111);
      chk("reset_lv", link_valid_o, 1'b0);

      // single read
      set_req(0, 32'h100, 1'b0, 32'h0);
      step();
      ch_req_valid_i = '0;
      step();
      chk("single_lv", link_valid_o, 1'b1);
      chk("single_addr", link_addr_o, 32'h100);
      chk("single_id", link_id_o, 0);
      step();
      send_rsp(0, 32'hDEADBEEF);
      chk("single_rsp_v", ch_rsp_valid_o[0], 1'b1);
      chk("single_rsp_d", ch_rsp_dat_o[31:0], 32'hDEADBEEF);
      chk("single_rsp_ready", ch_req_ready_o[0], 1'b1);
      step();
      chk("single_pulse_once", ch_rsp_valid_o[0], 1'b0);

      // contention from pointer 0
      do_reset();
      set_req(0, 32'h10, 1'b0, 32'h0);
      set_req(1, 32'h20, 1'b0, 32'h0);
      step();
      ch_req_valid_i = '0;
      step();
      chk("cont_first", link_id_o, 0);
      step();
      chk("cont_second", link_id_o, 1);
      step();
      send_rsp(0, 32'h1);
      send_rsp(1, 32'h2);
      set_req(0, 32'h30, 1'b0, 32'h0);
      step();
      ch_req_valid_i = '0;
      step();
      step();
      send_rsp(0, 32'h3);
      // pointer now at 1
      set_req(0, 32'h40, 1'b0, 32'h0);
      set_req(1, 32'h50, 1'b0, 32'h0);
      step();
      ch_req_valid_i = '0;
      step();
      chk("cont_ptr1_first", link_id_o, 1);
      step();
      chk("cont_ptr1_second", link_id_o, 0);
      step();
      // out-of-order completion
      send_rsp(1, 32'hAAAA_0001);
      chk("ooo_rsp1", ch_rsp_dat_o[63:32], 32'hAAAA_0001);
      send_rsp(0, 32'hBBBB_0000);
      chk("ooo_rsp0", ch_rsp_dat_o[31:0], 32'hBBBB_0000);
      chk("ooo_stray", stray_o, 1'b0);

      // backpressure on a write
      link_ready_i = 1'b0;
      set_req(0, 32'h200, 1'b1, 32'h1234);
      step();
      ch_req_valid_i = '0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_valid", link_valid_o, 1'b1);
         chk("bp_addr", link_addr_o, 32'h200);
         chk("bp_dat", link_dat_o, 32'h1234);
         chk("bp_we", link_we_o, 1'b1);
      end
      link_ready_i = 1'b1;
      step();
      chk("bp_consumed", link_valid_o, 1'b0);
      send_rsp(0, 32'h1234);

      // timeout on channel 2
      set_req(2, 32'h300, 1'b0, 32'h0);
      step();
      ch_req_valid_i = '0;
      step();
      for (int i = 1; i <= TMO; i++) begin
         step();
         if (i < TMO) chk("to_early", ch_rsp_valid_o[2], 1'b0);
      end
      chk("to_valid", ch_rsp_valid_o[2], 1'b1);
      chk("to_err", ch_rsp_err_o[2], 1'b1);
      chk("to_dat", ch_rsp_dat_o[95:64], 32'h0);
      send_rsp(2, 32'h5);
      chk("to_late_stray", stray_o, 1'b1);

      // response on the expiry cycle wins
      do_reset();
      set_req(1, 32'h400, 1'b0, 32'h0);
      step();
      ch_req_valid_i = '0;
      step();
      for (int i = 1; i < TMO; i++) step();
      send_rsp(1, 32'hC0DE);
      chk("race_valid", ch_rsp_valid_o[1], 1'b1);
      chk("race_err", ch_rsp_err_o[1], 1'b0);
      chk("race_stray", stray_o, 1'b0);

      // out-of-range id
      send_rsp(3, 32'h0);
      chk("id_range_stray", stray_o, 1'b1);

      // reset mid-flight
      do_reset();
      link_ready_i = 1'b0;
      set_req(0, 32'h500, 1'b0, 32'h0);
      step();
      ch_req_valid_i = '0;
      step();
      do_reset();
      chk("rst_lv", link_valid_o, 1'b0);
      chk("rst_ready", ch_req_ready_o, 3'b111);
      link_ready_i = 1'b1;
      send_rsp(0, 32'h9);
      chk("rst_stray", stray_o, 1'b1);

      // randomized traffic
      do_reset();
      for (int n = 0; n < 600; n++) begin
         for (int k = 0; k < NCH; k++) begin
            ch_req_valid_i[k] = ($urandom_range(0, 99) < 40);
            ch_req_addr_i[k*AW +: AW] = $urandom();
            ch_req_we_i[k] = $urandom_range(0, 1);
            ch_req_dat_i[k*DW +: DW] = $urandom();
         end
         link_ready_i = ($urandom_range(0, 99) < 70);
         cand.delete();
         for (int k = 0; k < NCH; k++) if (m_iss[k]) cand.push_back(k);
         link_rsp_valid_i = 1'b0;
         if (cand.size() > 0 && $urandom_range(0, 99) < 35) begin
            link_rsp_valid_i = 1'b1;
            link_rsp_id_i    = IDW'(cand[$urandom_range(0, cand.size() - 1)]);
            link_rsp_dat_i   = $urandom();
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
